// File: rtl/adc_trig_pkg.sv
// Shared types and the sample classifier for the ADC crossing trigger.
package adc_trig_pkg;

    // Widest sample the classifier handles; narrower data is zero-extended.
    localparam int unsigned CLS_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FIRED
    } state_t;

    typedef enum logic [1:0] {
        CLS_LOW,
        CLS_BAND,
        CLS_HIGH
    } cls_t;

    // Unsigned hysteresis classification: above hi is HIGH, below lo is LOW.
    function automatic cls_t classify(
        input logic [CLS_MAX_W-1:0] data,
        input logic [CLS_MAX_W-1:0] hi,
        input logic [CLS_MAX_W-1:0] lo
    );
        if (data > hi) begin
            return CLS_HIGH;
        end
        if (data < lo) begin
            return CLS_LOW;
        end
        return CLS_BAND;
    endfunction

endpackage

// File: rtl/adc_dwell_filter.sv
// Classifies accepted samples, debounces level changes over DWELL samples
// and holds the confirmed level. crossing is a combinational strobe that is
// high on the cycle whose edge confirms a crossing.
module adc_dwell_filter
    import adc_trig_pkg::*;
#(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned CH_W      = 5,
    parameter int unsigned CHANNEL   = 0,
    parameter int unsigned THRESH_HI = 3700,
    parameter int unsigned THRESH_LO = 3600,
    parameter int unsigned DWELL     = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              clear,
    input  logic              rearm,
    input  logic              idle,
    input  logic              track,
    input  logic              sample_valid,
    input  logic [CH_W-1:0]   sample_channel,
    input  logic [DATA_W-1:0] sample_data,
    output logic              level_high,
    output logic              crossing,
    output logic              init_hit
);

    localparam int unsigned DW = $clog2(DWELL + 1);
    localparam logic [DW-1:0] DWELL_MAX  = DW'(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DATA_W-1:0] HI = DATA_W'(THRESH_HI);
    localparam logic [DATA_W-1:0] LO = DATA_W'(THRESH_LO);

    logic [DW-1:0] dwell;
    logic          accepted;
    logic          opposite;
    cls_t          cls;

    // Sample acceptance, classification and crossing detection.
    always_comb begin
        accepted = sample_valid && (sample_channel == CH_W'(CHANNEL));
        cls      = classify(CLS_MAX_W'(sample_data), CLS_MAX_W'(HI), CLS_MAX_W'(LO));
        opposite = level_high ? (cls == CLS_LOW) : (cls == CLS_HIGH);
        crossing = accepted && track && opposite && (dwell == DWELL_LAST);
        init_hit = accepted && idle && (cls != CLS_BAND);
    end

    // Dwell counter and confirmed level register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            dwell      <= '0;
            level_high <= 1'b0;
        end else if (clear) begin
            dwell      <= '0;
            level_high <= 1'b0;
        end else if (rearm) begin
            dwell <= '0;
        end else if (init_hit) begin
            level_high <= (cls == CLS_HIGH);
            dwell      <= '0;
        end else if (accepted && track) begin
            if (crossing) begin
                level_high <= ~level_high;
                dwell      <= '0;
            end else if (opposite) begin
                if (dwell != DWELL_MAX) begin
                    dwell <= dwell + DW'(1);
                end
            end else begin
                dwell <= '0;
            end
        end
    end

endmodule

// File: rtl/adc_crossing_trigger.sv
// Threshold-crossing sequence detector: counts debounced crossings of one
// ADC channel and fires after NUM_CROSS of them within the timeout window.
module adc_crossing_trigger
    import adc_trig_pkg::*;
#(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned CH_W        = 5,
    parameter int unsigned CHANNEL     = 0,
    parameter int unsigned THRESH_HI   = 3700,
    parameter int unsigned THRESH_LO   = 3600,
    parameter int unsigned DWELL       = 4,
    parameter int unsigned NUM_CROSS   = 4,
    parameter int unsigned TIMEOUT_CYC = 50000000,
    parameter int unsigned STICKY      = 1
) (
    input  logic                           clk_in,
    input  logic                           rst,
    input  logic                           sample_valid,
    input  logic [CH_W-1:0]                sample_channel,
    input  logic [DATA_W-1:0]              sample_data,
    input  logic                           clear,
    output logic                           trigger,
    output logic                           trigger_pulse,
    output logic [$clog2(NUM_CROSS+1)-1:0] cross_count,
    output logic                           level_high,
    output logic                           armed
);

    localparam int unsigned CW = $clog2(NUM_CROSS + 1);
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] FIRE_PREV = CW'(NUM_CROSS - 1);
    localparam logic [TW-1:0] TMO_LAST  = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic          crossing;
    logic          init_hit;
    logic          expire;
    logic          fire;
    logic [CW-1:0] cnt_base;

    adc_dwell_filter #(
        .DATA_W    (DATA_W),
        .CH_W      (CH_W),
        .CHANNEL   (CHANNEL),
        .THRESH_HI (THRESH_HI),
        .THRESH_LO (THRESH_LO),
        .DWELL     (DWELL)
    ) u_filter (
        .clk_in         (clk_in),
        .rst            (rst),
        .clear          (clear),
        .rearm          ((state == FIRED) && (STICKY == 0)),
        .idle           (state == IDLE),
        .track          (state == TRACK),
        .sample_valid   (sample_valid),
        .sample_channel (sample_channel),
        .sample_data    (sample_data),
        .level_high     (level_high),
        .crossing       (crossing),
        .init_hit       (init_hit)
    );

    // Timeout expiry and firing condition; a crossing in the expiry cycle
    // counts from zero, so it lands on 1 rather than being lost.
    always_comb begin
        expire   = (TIMEOUT_CYC != 0) && (cross_count != '0) && (tmo_cnt == TMO_LAST);
        cnt_base = expire ? '0 : cross_count;
        fire     = crossing && (cnt_base == FIRE_PREV);
    end

    // State machine with crossing counter, timeout counter and trigger outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            trigger       <= 1'b0;
            trigger_pulse <= 1'b0;
            cross_count   <= '0;
            armed         <= 1'b0;
            tmo_cnt       <= '0;
        end else if (clear) begin
            state         <= IDLE;
            trigger       <= 1'b0;
            trigger_pulse <= 1'b0;
            cross_count   <= '0;
            armed         <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            trigger_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_hit) begin
                        state <= TRACK;
                        armed <= 1'b1;
                    end
                end
                TRACK: begin
                    if (crossing) begin
                        cross_count <= cnt_base + CW'(1);
                        tmo_cnt     <= '0;
                        if (fire) begin
                            trigger       <= 1'b1;
                            trigger_pulse <= 1'b1;
                            state         <= FIRED;
                        end
                    end else if (expire) begin
                        cross_count <= '0;
                        tmo_cnt     <= '0;
                    end else if ((cross_count != '0) && (TIMEOUT_CYC != 0)) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                FIRED: begin
                    if (STICKY == 0) begin
                        trigger     <= 1'b0;
                        cross_count <= '0;
                        tmo_cnt     <= '0;
                        state       <= TRACK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_crossing_trigger.sv
// Directed bench: sticky and pulse-mode instances share all inputs.
module tb_adc_crossing_trigger;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [4:0]  sample_channel;
    logic [11:0] sample_data;
    logic        clear;

    logic       trig_s, pulse_s, lvl_s, arm_s;
    logic [2:0] cnt_s;
    logic       trig_n, pulse_n, lvl_n, arm_n;
    logic [2:0] cnt_n;

    int passed = 0;
    int total  = 0;

    always #5 clk_in = ~clk_in;

    adc_crossing_trigger #(
        .DWELL       (2),
        .NUM_CROSS   (4),
        .TIMEOUT_CYC (100),
        .STICKY      (1),
        .CHANNEL     (0)
    ) u_dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .sample_channel (sample_channel),
        .sample_data    (sample_data),
        .clear          (clear),
        .trigger        (trig_s),
        .trigger_pulse  (pulse_s),
        .cross_count    (cnt_s),
        .level_high     (lvl_s),
        .armed          (arm_s)
    );

    adc_crossing_trigger #(
        .DWELL       (2),
        .NUM_CROSS   (4),
        .TIMEOUT_CYC (100),
        .STICKY      (0),
        .CHANNEL     (0)
    ) u_dut_ns (
        .clk_in         (clk_in),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .sample_channel (sample_channel),
        .sample_data    (sample_data),
        .clear          (clear),
        .trigger        (trig_n),
        .trigger_pulse  (pulse_n),
        .cross_count    (cnt_n),
        .level_high     (lvl_n),
        .armed          (arm_n)
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic exp_s(input string tag, input logic t, input logic p,
                         input logic [2:0] c, input logic l, input logic a);
        cmp({tag, ".trigger"},     8'(trig_s),  8'(t));
        cmp({tag, ".pulse"},       8'(pulse_s), 8'(p));
        cmp({tag, ".cross_count"}, 8'(cnt_s),   8'(c));
        cmp({tag, ".level_high"},  8'(lvl_s),   8'(l));
        cmp({tag, ".armed"},       8'(arm_s),   8'(a));
    endtask

    task automatic exp_n(input string tag, input logic t, input logic p,
                         input logic [2:0] c, input logic l, input logic a);
        cmp({tag, ".trigger"},     8'(trig_n),  8'(t));
        cmp({tag, ".pulse"},       8'(pulse_n), 8'(p));
        cmp({tag, ".cross_count"}, 8'(cnt_n),   8'(c));
        cmp({tag, ".level_high"},  8'(lvl_n),   8'(l));
        cmp({tag, ".armed"},       8'(arm_n),   8'(a));
    endtask

    // Present one valid sample for exactly one edge; returns #1 after that edge.
    task automatic sample(input logic [4:0] ch, input logic [11:0] d);
        sample_valid   = 1'b1;
        sample_channel = ch;
        sample_data    = d;
        @(posedge clk_in);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk_in);
        #1;
        clear = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
    endtask

    // Eight samples from confirmed HIGH: four DWELL=2 crossings, fires on the last.
    task automatic full_seq(input string tag, input bit on_ns);
        logic [11:0] vals [8];
        logic [2:0]  cnts [8];
        vals = '{12'd3500, 12'd3500, 12'd3800, 12'd3800, 12'd3500, 12'd3500, 12'd3800, 12'd3800};
        cnts = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
        for (int i = 0; i < 8; i++) begin
            sample(5'd0, vals[i]);
            if (on_ns) begin
                cmp($sformatf("%s[%0d].cnt", tag, i),  8'(cnt_n),  8'(cnts[i]));
                cmp($sformatf("%s[%0d].trig", tag, i), 8'(trig_n), (i == 7) ? 8'd1 : 8'd0);
            end else begin
                cmp($sformatf("%s[%0d].cnt", tag, i),  8'(cnt_s),  8'(cnts[i]));
                cmp($sformatf("%s[%0d].trig", tag, i), 8'(trig_s), (i == 7) ? 8'd1 : 8'd0);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        clear          = 1'b0;
        sample_valid   = 1'b0;
        sample_channel = '0;
        sample_data    = '0;
        @(posedge clk_in);
        #1;
        exp_s("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // IDLE: band sample ignored, first HIGH arms
        sample(5'd0, 12'd3650);
        exp_s("idle_band", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        sample(5'd0, 12'd3800);
        exp_s("idle_arm", 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Full sequence, sticky fire
        full_seq("seq_s", 1'b0);
        exp_s("fire_edge", 1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
        idle_cycles(1);
        exp_s("fire_hold", 1'b1, 1'b0, 3'd4, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            sample(5'd0, (i % 4 < 2) ? 12'd3500 : 12'd3800);
        end
        exp_s("sticky_20", 1'b1, 1'b0, 3'd4, 1'b1, 1'b1);
        pulse_clear();
        exp_s("clear", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // Channel filter, then debounce
        sample(5'd0, 12'd3800);
        for (int i = 0; i < 4; i++) begin
            sample(5'd3, 12'd100);
        end
        exp_s("ch3_ignored", 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        sample(5'd0, 12'd3500);
        sample(5'd0, 12'd3650);
        sample(5'd0, 12'd3500);
        sample(5'd0, 12'd3800);
        sample(5'd0, 12'd3500);
        exp_s("debounce_hold", 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        sample(5'd0, 12'd3500);
        exp_s("debounce_cross", 1'b0, 1'b0, 3'd1, 1'b0, 1'b1);

        // Timeout: count drops on the 100th cycle after the crossing
        idle_cycles(99);
        cmp("tmo_99.cnt", 8'(cnt_s), 8'd1);
        idle_cycles(1);
        exp_s("tmo_100", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

        // Crossing landing on the expiry cycle counts as 1
        sample(5'd0, 12'd3800);
        sample(5'd0, 12'd3800);
        cmp("tmo2_start.cnt", 8'(cnt_s), 8'd1);
        idle_cycles(98);
        sample(5'd0, 12'd3500);
        cmp("tmo2_99.cnt", 8'(cnt_s), 8'd1);
        sample(5'd0, 12'd3500);
        exp_s("tmo2_collide", 1'b0, 1'b0, 3'd1, 1'b0, 1'b1);

        // Pulse mode: one-cycle trigger, rearm, fire again
        pulse_rst();
        sample(5'd0, 12'd3800);
        exp_n("ns_arm", 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        full_seq("seq_n1", 1'b1);
        exp_n("ns_fire1", 1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
        idle_cycles(1);
        exp_n("ns_rearm", 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        full_seq("seq_n2", 1'b1);
        exp_n("ns_fire2", 1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
        idle_cycles(1);
        exp_n("ns_rearm2", 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Async reset between edges while FIRED
        pulse_rst();
        sample(5'd0, 12'd3800);
        full_seq("seq_rst", 1'b0);
        exp_s("pre_rst", 1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        exp_s("async_rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        idle_cycles(1);
        exp_s("post_rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // clear coinciding with the 4th crossing suppresses the fire
        sample(5'd0, 12'd3800);
        sample(5'd0, 12'd3500);
        sample(5'd0, 12'd3500);
        sample(5'd0, 12'd3800);
        sample(5'd0, 12'd3800);
        sample(5'd0, 12'd3500);
        sample(5'd0, 12'd3500);
        sample(5'd0, 12'd3800);
        cmp("clr_pre.cnt", 8'(cnt_s), 8'd3);
        clear = 1'b1;
        sample(5'd0, 12'd3800);
        clear = 1'b0;
        exp_s("clr_collide", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle_cycles(1);
        cmp("clr_after.trig", 8'(trig_s), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
